// File: rtl/hififo_tpc_mux.sv
// hififo_tpc_mux: multi-channel to-PC DMA write engine.
// Show-ahead FIFO per channel feeding a round-robin burst arbiter.
module hififo_tpc_mux #(
    parameter int NCH        = 2,
    parameter int BURST      = 16,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NCH-1:0]    chan_enable,
    input  logic [NCH-1:0]    fifo_write,
    input  logic [64*NCH-1:0] fifo_data,
    output logic [NCH-1:0]    fifo_ready,
    output logic [NCH-1:0]    overflow,
    input  logic [NCH-1:0]    req_valid,
    input  logic [64*NCH-1:0] req_addr,
    output logic [NCH-1:0]    req_ack,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [63:0]       wr_data,
    output logic [63:0]       wr_addr,
    output logic [5:0]        wr_count,
    output logic              wr_last,
    output logic [2:0]        wr_chan
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int FW = DEPTH_LOG2 + 1;
    localparam logic [5:0] LAST = 6'(BURST - 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t state, state_nx;

    logic [NCH-1:0]         elig;
    logic [NCH-1:0]         push;
    logic [NCH-1:0]         pop;
    logic [NCH-1:0][63:0]   head;
    logic [2:0]             rr_ptr;
    logic [5:0]             beat;
    logic                   grant_ok;
    logic [2:0]             grant_idx;
    logic [63:0]            sel_addr;
    logic                   accept;
    logic                   done;

    assign accept = wr_valid && wr_ready;
    assign done = accept && wr_last;
    assign wr_count = 6'(BURST);

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        logic [63:0]           mem [DEPTH];
        logic [DEPTH_LOG2-1:0] wr_q;
        logic [DEPTH_LOG2-1:0] rd_q;
        logic [FW-1:0]         fill_q;
        logic                  ovf_q;

        assign fifo_ready[n] = fill_q < FW'(DEPTH);
        assign push[n] = fifo_write[n] && fifo_ready[n];
        assign pop[n] = accept && (wr_chan == 3'(n));
        assign elig[n] = chan_enable[n] && req_valid[n]
                         && (fill_q >= FW'(BURST));
        assign head[n] = mem[rd_q];
        assign overflow[n] = ovf_q;

        always_ff @(posedge clock) begin
            if (push[n]) begin
                mem[wr_q] <= fifo_data[64*n +: 64];
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                wr_q   <= '0;
                rd_q   <= '0;
                fill_q <= '0;
                ovf_q  <= 1'b0;
            end else begin
                if (push[n]) wr_q <= wr_q + DEPTH_LOG2'(1);
                if (pop[n]) rd_q <= rd_q + DEPTH_LOG2'(1);
                if (push[n] && !pop[n]) begin
                    fill_q <= fill_q + FW'(1);
                end else if (pop[n] && !push[n]) begin
                    fill_q <= fill_q - FW'(1);
                end
                if (fifo_write[n] && !fifo_ready[n]) ovf_q <= 1'b1;
            end
        end
    end

    // Smallest rotated distance from rr_ptr wins.
    always_comb begin
        int d;
        int best;
        d = 0;
        best = NCH;
        grant_ok = 1'b0;
        grant_idx = '0;
        for (int n = 0; n < NCH; n++) begin
            d = n - int'(rr_ptr);
            if (d < 0) d = d + NCH;
            if (elig[n] && d < best) begin
                best = d;
                grant_ok = 1'b1;
                grant_idx = 3'(n);
            end
        end
    end

    always_comb begin
        wr_data = '0;
        sel_addr = '0;
        for (int n = 0; n < NCH; n++) begin
            if (wr_chan == 3'(n)) wr_data = head[n];
            if (grant_idx == 3'(n)) sel_addr = req_addr[64*n +: 64];
        end
    end

    always_comb begin
        state_nx = state;
        wr_valid = 1'b0;
        wr_last = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_ok) state_nx = XFER;
            end
            XFER: begin
                wr_valid = 1'b1;
                wr_last = (beat == LAST);
                if (wr_ready && wr_last) state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            beat    <= '0;
            rr_ptr  <= '0;
            wr_chan <= '0;
            wr_addr <= '0;
            req_ack <= '0;
        end else begin
            state   <= state_nx;
            req_ack <= '0;
            if (state == IDLE && grant_ok) begin
                wr_chan <= grant_idx;
                wr_addr <= sel_addr;
                beat    <= '0;
            end
            if (accept) beat <= beat + 6'd1;
            if (done) begin
                req_ack <= NCH'(1) << wr_chan;
                rr_ptr  <= (wr_chan == 3'(NCH - 1)) ? 3'd0
                                                    : wr_chan + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_hififo_tpc_mux.sv
// Directed bench for hififo_tpc_mux (NCH=2, BURST=16, depth 32).
module tb_hififo_tpc_mux;
    localparam int NCH = 2;
    localparam int BURST = 16;
    localparam int DL = 5;

    logic              clock = 1'b0;
    logic              reset;
    logic [NCH-1:0]    chan_enable;
    logic [NCH-1:0]    fifo_write;
    logic [64*NCH-1:0] fifo_data;
    logic [NCH-1:0]    fifo_ready;
    logic [NCH-1:0]    overflow;
    logic [NCH-1:0]    req_valid;
    logic [64*NCH-1:0] req_addr;
    logic [NCH-1:0]    req_ack;
    logic              wr_valid;
    logic              wr_ready;
    logic [63:0]       wr_data;
    logic [63:0]       wr_addr;
    logic [5:0]        wr_count;
    logic              wr_last;
    logic [2:0]        wr_chan;

    hififo_tpc_mux #(
        .NCH(NCH), .BURST(BURST), .DEPTH_LOG2(DL)
    ) dut (
        .clock(clock), .reset(reset),
        .chan_enable(chan_enable),
        .fifo_write(fifo_write), .fifo_data(fifo_data),
        .fifo_ready(fifo_ready), .overflow(overflow),
        .req_valid(req_valid), .req_addr(req_addr),
        .req_ack(req_ack),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_addr(wr_addr),
        .wr_count(wr_count), .wr_last(wr_last),
        .wr_chan(wr_chan)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          chan;
        logic [63:0] data;
        logic [63:0] addr;
        logic        last;
        int          cyc;
    } beat_t;

    typedef struct {
        int         reps;
        logic [1:0] en;
        logic [1:0] wr;
        logic [1:0] rv;
        logic       ev;
        logic [1:0] er;
        logic [1:0] eo;
    } vec_t;

    beat_t       beats[$];
    int          acks_ch[$];
    int          ack_cyc[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        stall_q = 1'b0;
    logic [63:0] stall_d;
    logic [2:0]  stall_c;

    task automatic check(string name, logic [63:0] got,
                         logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_data(int n, logic [63:0] v);
        fifo_data[64*n +: 64] = v;
    endtask

    task automatic set_addr(int n, logic [63:0] v);
        req_addr[64*n +: 64] = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        chan_enable = '0;
        fifo_write = '0;
        fifo_data = '0;
        req_valid = '0;
        req_addr = '0;
        wr_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        beats.delete();
        acks_ch.delete();
        ack_cyc.delete();
    endtask

    task automatic wait_beats(string name, int n, int maxc);
        for (int c = 0; c < maxc && beats.size() < n; c++) step();
        check(name, 64'(beats.size()), 64'(n));
    endtask

    // Beat/ack logger plus stall-hold checker.
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_valid", 64'(wr_valid), 64'd1);
                check("stall_data", wr_data, stall_d);
                check("stall_chan", 64'(wr_chan), 64'(stall_c));
            end
            if (wr_valid && wr_ready) begin
                beats.push_back('{int'(wr_chan), wr_data, wr_addr,
                                  wr_last, cyc});
            end
            for (int n = 0; n < NCH; n++) begin
                if (req_ack[n]) begin
                    acks_ch.push_back(n);
                    ack_cyc.push_back(cyc);
                end
            end
            stall_q = wr_valid && !wr_ready;
            stall_d = wr_data;
            stall_c = wr_chan;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: sim time limit");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        logic pat[4];
        logic [63:0] cnt0, cnt1;
        int base;

        // Test 1: single burst on ch0
        do_reset();
        @(negedge clock);
        check("rst_valid", 64'(wr_valid), 64'd0);
        check("rst_last", 64'(wr_last), 64'd0);
        check("rst_ack", 64'(req_ack), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_ready", 64'(fifo_ready), 64'd3);
        check("rst_chan", 64'(wr_chan), 64'd0);
        check("wr_count", 64'(wr_count), 64'd16);
        step();
        chan_enable = 2'b11;
        req_valid = 2'b01;
        set_addr(0, 64'h1000);
        for (int i = 0; i < 16; i++) begin
            fifo_write = 2'b01;
            set_data(0, 64'(i));
            step();
        end
        fifo_write = '0;
        wait_beats("t1_beats", 16, 40);
        for (int i = 0; i < 6; i++) step();
        check("t1_total", 64'(beats.size()), 64'd16);
        for (int i = 0; i < beats.size() && i < 16; i++) begin
            check("t1_data", beats[i].data, 64'(i));
            check("t1_chan", 64'(beats[i].chan), 64'd0);
            check("t1_addr", beats[i].addr, 64'h1000);
            check("t1_last", 64'(beats[i].last), 64'(i == 15));
            check("t1_cyc", 64'(beats[i].cyc), 64'(beats[0].cyc + i));
        end
        check("t1_nack", 64'(acks_ch.size()), 64'd1);
        if (acks_ch.size() == 1 && beats.size() == 16) begin
            check("t1_ack_ch", 64'(acks_ch[0]), 64'd0);
            check("t1_ack_cyc", 64'(ack_cyc[0]),
                  64'(beats[15].cyc + 1));
        end

        // Test 2: round robin, 32 qwords per channel
        do_reset();
        chan_enable = 2'b11;
        set_addr(0, 64'hA000);
        set_addr(1, 64'hB000);
        for (int i = 0; i < 32; i++) begin
            fifo_write = 2'b11;
            set_data(0, 64'h100 + 64'(i));
            set_data(1, 64'h200 + 64'(i));
            step();
        end
        fifo_write = '0;
        req_valid = 2'b11;
        wait_beats("t2_beats", 64, 200);
        for (int i = 0; i < 4; i++) step();
        for (int k = 0; k < beats.size() && k < 64; k++) begin
            int b, i, ch;
            b = k / 16;
            i = k % 16;
            ch = b % 2;
            check("t2_chan", 64'(beats[k].chan), 64'(ch));
            check("t2_data", beats[k].data,
                  (ch == 1 ? 64'h200 : 64'h100) + 64'(16 * (b / 2) + i));
            check("t2_addr", beats[k].addr,
                  ch == 1 ? 64'hB000 : 64'hA000);
            check("t2_last", 64'(beats[k].last), 64'(i == 15));
            if (k > 0) begin
                check("t2_gap", 64'(beats[k].cyc - beats[k-1].cyc),
                      i == 0 ? 64'd2 : 64'd1);
            end
        end
        check("t2_nack", 64'(acks_ch.size()), 64'd4);
        for (int b = 0; b < acks_ch.size() && b < 4; b++) begin
            check("t2_ack_ch", 64'(acks_ch[b]), 64'(b % 2));
        end

        // Test 3: backpressure 1,0,0,1
        do_reset();
        chan_enable = 2'b01;
        req_valid = 2'b01;
        set_addr(0, 64'h3000);
        wr_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            fifo_write = 2'b01;
            set_data(0, 64'h300 + 64'(i));
            step();
        end
        fifo_write = '0;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 200 && beats.size() < 16; k++) begin
            wr_ready = pat[k % 4];
            step();
        end
        wr_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("t3_beats", 64'(beats.size()), 64'd16);
        for (int i = 0; i < beats.size() && i < 16; i++) begin
            check("t3_data", beats[i].data, 64'h300 + 64'(i));
            check("t3_last", 64'(beats[i].last), 64'(i == 15));
        end
        check("t3_nack", 64'(acks_ch.size()), 64'd1);

        // Tests 4/5: threshold, enable, full and overflow
        tbl.push_back('{15, 2'b01, 2'b01, 2'b01, 1'b0, 2'b11, 2'b00});
        tbl.push_back('{ 1, 2'b00, 2'b01, 2'b01, 1'b0, 2'b11, 2'b00});
        tbl.push_back('{ 3, 2'b00, 2'b00, 2'b01, 1'b0, 2'b11, 2'b00});
        tbl.push_back('{ 1, 2'b01, 2'b00, 2'b01, 1'b0, 2'b11, 2'b00});
        tbl.push_back('{16, 2'b00, 2'b00, 2'b00, 1'b1, 2'b11, 2'b00});
        tbl.push_back('{ 3, 2'b11, 2'b00, 2'b00, 1'b0, 2'b11, 2'b00});
        tbl.push_back('{32, 2'b11, 2'b10, 2'b00, 1'b0, 2'b11, 2'b00});
        tbl.push_back('{ 1, 2'b11, 2'b10, 2'b00, 1'b0, 2'b01, 2'b00});
        tbl.push_back('{ 2, 2'b11, 2'b00, 2'b00, 1'b0, 2'b01, 2'b10});
        tbl.push_back('{ 1, 2'b11, 2'b00, 2'b10, 1'b0, 2'b01, 2'b10});
        tbl.push_back('{ 1, 2'b11, 2'b00, 2'b10, 1'b1, 2'b01, 2'b10});
        tbl.push_back('{15, 2'b11, 2'b00, 2'b10, 1'b1, 2'b11, 2'b10});
        tbl.push_back('{ 1, 2'b11, 2'b00, 2'b10, 1'b0, 2'b11, 2'b10});
        tbl.push_back('{16, 2'b11, 2'b00, 2'b10, 1'b1, 2'b11, 2'b10});
        tbl.push_back('{ 3, 2'b11, 2'b00, 2'b10, 1'b0, 2'b11, 2'b10});
        do_reset();
        set_addr(0, 64'h5000);
        set_addr(1, 64'h4000);
        cnt0 = 64'h500;
        cnt1 = 64'h400;
        for (int r = 0; r < tbl.size(); r++) begin
            for (int k = 0; k < tbl[r].reps; k++) begin
                chan_enable = tbl[r].en;
                req_valid = tbl[r].rv;
                fifo_write = tbl[r].wr;
                set_data(0, cnt0);
                set_data(1, cnt1);
                @(negedge clock);
                check($sformatf("tv%0d_valid", r), 64'(wr_valid),
                      64'(tbl[r].ev));
                check($sformatf("tv%0d_ready", r), 64'(fifo_ready),
                      64'(tbl[r].er));
                check($sformatf("tv%0d_ovf", r), 64'(overflow),
                      64'(tbl[r].eo));
                step();
                if (tbl[r].wr[0]) cnt0 = cnt0 + 64'd1;
                if (tbl[r].wr[1]) cnt1 = cnt1 + 64'd1;
            end
        end
        fifo_write = '0;
        check("tv_beats", 64'(beats.size()), 64'd48);
        for (int k = 0; k < beats.size() && k < 48; k++) begin
            check("tv_chan", 64'(beats[k].chan), k < 16 ? 64'd0 : 64'd1);
            check("tv_data", beats[k].data,
                  k < 16 ? 64'h500 + 64'(k) : 64'h400 + 64'(k - 16));
            check("tv_addr", beats[k].addr,
                  k < 16 ? 64'h5000 : 64'h4000);
            check("tv_last", 64'(beats[k].last), 64'(k % 16 == 15));
        end
        check("tv_nack", 64'(acks_ch.size()), 64'd3);

        // Test 6: reset at beat 7 of a ch1 burst
        do_reset();
        chan_enable = 2'b11;
        set_addr(0, 64'h6000);
        set_addr(1, 64'h7000);
        for (int i = 0; i < 33; i++) begin
            fifo_write = (i < 16) ? 2'b11 : 2'b10;
            set_data(0, 64'h600 + 64'(i));
            set_data(1, 64'h700 + 64'(i));
            step();
        end
        fifo_write = '0;
        req_valid = 2'b01;
        wait_beats("t6_ch0", 16, 40);
        step();
        step();
        req_valid = 2'b10;
        wait_beats("t6_beat7", 23, 40);
        check("t6_pre_ovf", 64'(overflow), 64'd2);
        reset = 1'b1;
        step();
        @(negedge clock);
        check("t6_valid", 64'(wr_valid), 64'd0);
        check("t6_ack", 64'(req_ack), 64'd0);
        check("t6_ready", 64'(fifo_ready), 64'd3);
        check("t6_ovf", 64'(overflow), 64'd0);
        check("t6_nack", 64'(acks_ch.size()), 64'd1);
        step();
        reset = 1'b0;
        base = beats.size();
        req_valid = 2'b00;
        for (int i = 0; i < 16; i++) begin
            fifo_write = 2'b11;
            set_data(0, 64'h800 + 64'(i));
            set_data(1, 64'h900 + 64'(i));
            step();
        end
        fifo_write = '0;
        req_valid = 2'b11;
        wait_beats("t6_post", base + 32, 100);
        if (beats.size() >= base + 32) begin
            check("t6_first_ch", 64'(beats[base].chan), 64'd0);
            check("t6_first_d", beats[base].data, 64'h800);
            check("t6_ch1_ch", 64'(beats[base+16].chan), 64'd1);
            check("t6_ch1_d", beats[base+16].data, 64'h900);
            check("t6_ch1_end", beats[base+31].data, 64'h90f);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
